bcd_gate_counter: RTL
=====================

Name: bcd_gate_counter

Overview:
Fully synchronous, parametrised BCD frequency counter. It succeeds the rippled per-digit counter chain with a single-clock design. An asynchronous input signal is synchronised and edge-detected. Rising edges are counted in a packed BCD accumulator during a gate window of GATE_CYCLES clocks. At window end the result is latched and flagged valid. It sits between the external signal pin and the display/readout logic of the frequency meter.

Parameters:
DIG_WIDTH, 8, number of BCD digits (accumulator width = DIG_WIDTH*4)
GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); must be >= 2
SYNC_STAGES, 2, synchroniser depth for sig_i; must be >= 2
CONTINUOUS, 0, 1 = restart a new window immediately after each result; 0 = one window per start_i

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low
start_i  input  1  start one measurement; sampled only in IDLE
sig_i  input  1  asynchronous signal to be measured
busy_o  output  1  high while a window is open (COUNT state)
valid_o  output  1  one-cycle pulse when count_o/ovf_o update
count_o  output  DIG_WIDTH*4  latched BCD result, digit 0 in bits [3:0]
ovf_o  output  1  latched: accumulator overflowed during the window

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; synchroniser, edge register, gate counter and accumulator cleared; busy_o=0, valid_o=0, count_o=0, ovf_o=0. Reset mid-window discards the window; after release no valid_o until a new start (or, with CONTINUOUS=1, a start_i).
- Synchroniser: sig_i passes through SYNC_STAGES flops. edge = sync_last & ~sync_prev. An edge pulse reaches the accumulator SYNC_STAGES+1 cycles after the sig_i rise. Pulses shorter than one clk period may be missed; this is acceptable.
- FSM states: IDLE, COUNT, DONE.
- IDLE: busy_o=0. When start_i=1, clear the accumulator and the overflow flag, set gate_cnt=0 and move to COUNT.
- COUNT: busy_o=1 and gate_cnt increments every cycle.
  - Each edge pulse adds 1 to the accumulator. The ripple carry between digits is combinational in the same cycle: digit d increments when all lower digits are 9; a digit at 9 wraps to 0.
  - The state moves to DONE in the cycle where gate_cnt==GATE_CYCLES-1. An edge in that cycle is still counted.
  - start_i is ignored.
- DONE (one cycle): count_o<=accumulator, ovf_o<=overflow flag, valid_o=1, busy_o=0.
  - CONTINUOUS=0: return to IDLE; an edge pulse in this cycle is dropped.
  - CONTINUOUS=1: go to COUNT with gate_cnt=0. The accumulator is loaded with 1 if an edge pulse occurs this cycle, otherwise 0. No edge is lost or double-counted across windows.
- Overflow: when the accumulator is all 9s and an edge arrives, the overflow flag is set and stays sticky until the next window start. What the accumulator does next depends on BCD_SATURATE_EN.
- count_o and ovf_o hold their value between valid_o pulses.
- Window length in single mode: valid_o asserts GATE_CYCLES+1 cycles after the clock edge that accepts start_i.

Optional Feature:
Macro BCD_SATURATE_EN.
- Defined: on overflow the accumulator saturates at all 9s and further edges are ignored.
- Undefined: the accumulator wraps modulo 10^DIG_WIDTH.
- ovf_o behaves identically in both builds.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=2'd0, COUNT=2'd1, DONE=2'd2)
  - BCD_DIGIT_MAX=4'd9
  - BCD_DIGIT_W=4
- Sub-module bcd_digit:
  - Single synchronous digit with clk, rst, clr_i, load_i, inc_i.
  - Outputs q[3:0] and at_max_o (q==9).
  - The top instantiates DIG_WIDTH copies in a generate loop and builds the carry chain from the at_max_o outputs.
- Gate counter and FSM stay in the top module.

Test Plan:
1. DIG_WIDTH=4, GATE_CYCLES=100, sig_i period 4 clk, start_i pulse -> valid_o once at cycle 101 after start; count_o=16'h0025, ovf_o=0.
2. DIG_WIDTH=2, GATE_CYCLES=250, sig_i period 2 (125 edges) -> BCD_SATURATE_EN undefined: count_o=8'h25, ovf_o=1; defined: count_o=8'h99, ovf_o=1.
3. DIG_WIDTH=4, exactly 199 edges in the window -> count_o=16'h0199. Carry 0x0099->0x0100 is checked each cycle; no non-BCD digit value ever appears.
4. start_i pulsed repeatedly during COUNT -> ignored; exactly one valid_o, and window length is unchanged at 101 cycles.
5. rst asserted low at cycle 50 of a window, released at 60 -> all outputs 0 immediately; no valid_o afterwards until start_i, and the next result counts only post-start edges.
6. CONTINUOUS=1, GATE_CYCLES=100, sig_i period 3 over 10 windows, with an edge forced into a DONE cycle -> valid_o every 101 cycles; the sum of all count_o values equals the total edges counted by the bench.

Source files
------------

// File: rtl/bcd_gate_counter_pkg.sv
// rtl/bcd_gate_counter_pkg.sv - shared FSM encoding, BCD digit constants and digit increment helper
package bcd_gate_counter_pkg;

    localparam int                     BCD_DIGIT_W   = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [BCD_DIGIT_W-1:0] bcd_next(input logic [BCD_DIGIT_W-1:0] d);
        return (d == BCD_DIGIT_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one synchronous BCD digit with clear, load-one and increment
module bcd_digit
    import bcd_gate_counter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic                   inc_i,
    output logic [BCD_DIGIT_W-1:0] q,
    output logic                   at_max_o
);

    logic [BCD_DIGIT_W-1:0] r_q;

    // load_i seeds the digit with 1 so a window can open on a counted edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr_i) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= 4'd1;
        end else if (inc_i) begin
            r_q <= bcd_next(r_q);
        end
    end

    assign q        = r_q;
    assign at_max_o = (r_q == BCD_DIGIT_MAX);

endmodule

// File: rtl/bcd_gate_counter.sv
// rtl/bcd_gate_counter.sv - gated BCD frequency counter; BCD_SATURATE_EN selects saturate-at-all-9s over wrap
module bcd_gate_counter
    import bcd_gate_counter_pkg::*;
#(
    parameter int DIG_WIDTH   = 8,
    parameter int GATE_CYCLES = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int CONTINUOUS  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic                             sig_i,
    output logic                             busy_o,
    output logic                             valid_o,
    output logic [DIG_WIDTH*BCD_DIGIT_W-1:0] count_o,
    output logic                             ovf_o
);

    localparam int                ACC_W     = DIG_WIDTH * BCD_DIGIT_W;
    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    state_t                 r_state;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic                   r_busy;
    logic                   r_valid;
    logic [ACC_W-1:0]       r_count;
    logic                   r_ovf;
    logic                   r_ovf_flag;

    logic                   w_edge;
    logic                   w_start;
    logic                   w_restart;
    logic                   w_counting;
    logic                   w_all_max;
    logic                   w_inc;
    logic [ACC_W-1:0]       w_acc;
    logic [DIG_WIDTH-1:0]   w_at_max;
    logic [DIG_WIDTH-1:0]   w_carry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_start    = (r_state == IDLE) & start_i;
    assign w_restart  = (r_state == DONE) & (CONTINUOUS != 0);
    assign w_counting = (r_state == COUNT);
    assign w_all_max  = &w_at_max;

`ifdef BCD_SATURATE_EN
    assign w_inc = w_counting & w_edge & ~w_all_max;
`else
    assign w_inc = w_counting & w_edge;
`endif

    // Carry into digit d is the whole-accumulator increment gated by all lower digits sitting at 9
    for (genvar d = 0; d < DIG_WIDTH; d++) begin : g_digit
        logic w_clr;
        logic w_load;

        if (d == 0) begin : g_lsd
            assign w_clr      = w_start | (w_restart & ~w_edge);
            assign w_load     = w_restart & w_edge;
            assign w_carry[d] = w_inc;
        end else begin : g_upper
            assign w_clr      = w_start | w_restart;
            assign w_load     = 1'b0;
            assign w_carry[d] = w_inc & (&w_at_max[d-1:0]);
        end

        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (w_clr),
            .load_i   (w_load),
            .inc_i    (w_carry[d]),
            .q        (w_acc[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .at_max_o (w_at_max[d])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_flag <= 1'b0;
        end else if (w_start | w_restart) begin
            r_ovf_flag <= 1'b0;
        end else if (w_counting & w_edge & w_all_max) begin
            r_ovf_flag <= 1'b1;
        end
    end

    // DONE latches the accumulator one cycle after the last gate cycle so its final edge is included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state    <= COUNT;
                        r_gate_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                COUNT: begin
                    r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                    if (r_gate_cnt == GATE_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    r_count <= w_acc;
                    r_ovf   <= r_ovf_flag;
                    r_valid <= 1'b1;
                    if (CONTINUOUS != 0) begin
                        r_state    <= COUNT;
                        r_gate_cnt <= '0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign valid_o = r_valid;
    assign count_o = r_count;
    assign ovf_o   = r_ovf;

endmodule
